control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL expose the parameter OP_W, default 4, giving the opcode width.
REQ-002 The block SHALL expose the parameter STEP_W, default 2, giving the step-counter and length-field width.
REQ-003 The block SHALL expose the parameter LEN_TABLE, width STEP_W*2^OP_W, default 32'hAAAA_5555; field k (LEN_TABLE[k*STEP_W +: STEP_W]) is the execute-cycle count of opcode k.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- i_clk  in  1  rising-edge clock
- i_rst  in  1  reset; asynchronous, active-low
- i_opcode  in  OP_W  opcode presented during FETCH
- i_stall  in  1  hold sequencer in current state/step
- i_irq  in  1  interrupt request, level
- o_state  out  2  00 IDLE, 01 FETCH, 10 EXEC, 11 IRQ
- o_step  out  STEP_W  current execute step
- o_opcode  out  OP_W  opcode latched at end of FETCH
- o_fetch  out  1  PC/IR write strobe
- o_exec  out  1  EXEC state indicator
- o_done  out  1  last execute step completes this cycle
- o_irq_ack  out  1  interrupt acknowledge

Function
REQ-005 The state register SHALL hold one of IDLE, FETCH, EXEC or IRQ, with encodings as given for o_state.
- r_step is STEP_W bits.
- r_opcode is OP_W bits.
REQ-006 IDLE SHALL go to FETCH on the next rising edge unconditionally, ignoring i_stall and i_irq.
REQ-007 FETCH SHALL resolve as follows, in priority order.
- i_stall=1: hold FETCH.
- Else i_irq=1: go to IRQ; r_opcode unchanged.
- Else latch r_opcode<=i_opcode, r_step<=0, then with L=LEN_TABLE field of i_opcode: L=0 stays in FETCH, L>0 goes to EXEC.
REQ-008 EXEC SHALL resolve as follows, with L=LEN_TABLE field of r_opcode.
- i_stall=1: hold state and r_step.
- Else r_step==L-1: go to FETCH with r_step<=0.
- Else r_step<=r_step+1.
REQ-009 IRQ SHALL last exactly one cycle and then go to FETCH, regardless of i_stall or i_irq.
REQ-010 i_irq SHALL be sampled only in FETCH; a request raised in EXEC is deferred to the next non-stalled FETCH.
REQ-011 Outputs SHALL be driven as follows.
- o_fetch = (state==FETCH) & ~i_stall & ~i_irq.
- o_exec = (state==EXEC).
- o_done = (state==EXEC) & ~i_stall & (r_step==L-1).
- o_irq_ack = (state==IRQ).
- o_step = r_step; o_opcode = r_opcode; o_state = state.
REQ-012 Maximum execute length SHALL be 2^STEP_W-1 cycles; r_step SHALL never exceed 2^STEP_W-2 and SHALL never wrap.
REQ-013 Stall and irq asserted together in FETCH SHALL resolve to stall (hold); the irq is taken on the first unstalled FETCH cycle if still asserted.
REQ-014 Throughput SHALL be 1+L cycles per instruction with no stalls; an L=0 opcode SHALL issue o_fetch on consecutive cycles.

Reset
REQ-015 While i_rst=0, the block SHALL asynchronously force the following.
- state=IDLE, r_step=0, r_opcode=0.
- o_fetch, o_exec, o_done, o_irq_ack all 0.
REQ-016 Reset asserted mid-EXEC or mid-IRQ SHALL abort the operation immediately with no o_done or o_irq_ack pulse, and the block SHALL resume at IDLE after i_rst returns to 1.

Verification
REQ-017 The bench SHALL cover reset: i_rst=0 for 1 ns -> o_state=00 and all outputs 0; after release, first edge -> o_state=01.
REQ-018 The bench SHALL cover a short opcode: FETCH with i_opcode=4'h3 (L=1) -> EXEC with o_step=0 and o_done=1 -> FETCH; total 2 cycles.
REQ-019 The bench SHALL cover a long opcode: i_opcode=4'hC (L=2) -> EXEC steps 0 then 1, o_done=1 only at step 1, o_opcode=4'hC throughout.
REQ-020 The bench SHALL cover stall: opcode 4'hC, i_stall=1 for 2 cycles at step 0 -> o_step stays 0 and o_done=0; after release, steps 0 then 1 complete normally.
REQ-021 The bench SHALL cover interrupts in two phases.
- i_irq=1 in FETCH -> IRQ for 1 cycle with o_irq_ack=1 and o_fetch=0 -> FETCH.
- i_irq raised during EXEC step 0 -> no ack until the following FETCH.
REQ-022 The bench SHALL cover zero-length opcodes and mid-operation reset.
- LEN_TABLE with field 0 = 0, i_opcode=0 -> o_state stays 01 and o_fetch=1 every cycle.
- i_rst=0 pulsed mid-EXEC -> o_state=00 immediately, no o_done.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: IDLE -> FETCH -> EXEC (per-opcode length) -> FETCH,
// with a single-cycle IRQ acknowledge state taken only from an unstalled FETCH.
module control_sequencer #(
  parameter int OP_W   = 4,
  parameter int STEP_W = 2,
  parameter logic [STEP_W*(2**OP_W)-1:0] LEN_TABLE = 32'hAAAA_5555
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic              i_stall,
  input  logic              i_irq,
  output logic [1:0]        o_state,
  output logic [STEP_W-1:0] o_step,
  output logic [OP_W-1:0]   o_opcode,
  output logic              o_fetch,
  output logic              o_exec,
  output logic              o_done,
  output logic              o_irq_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_IRQ   = 2'b11
  } state_t;

  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [STEP_W-1:0] step_r, step_s;
  logic [OP_W-1:0]   opcode_r, opcode_s;
  logic [STEP_W-1:0] exec_last_s;
  logic              last_step_s;

  function automatic logic [STEP_W-1:0] len_of(input logic [OP_W-1:0] op);
    len_of = LEN_TABLE[op*STEP_W +: STEP_W];
  endfunction

  // EXEC is only entered with a nonzero length, so L-1 never underflows there
  assign exec_last_s = len_of(opcode_r) - STEP_ONE;
  assign last_step_s = (step_r == exec_last_s);

  // Next-state, step/opcode update and strobe decode
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    opcode_s  = opcode_r;
    o_fetch   = 1'b0;
    o_exec    = 1'b0;
    o_done    = 1'b0;
    o_irq_ack = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_stall) begin
          state_s = ST_FETCH;
        end else if (i_irq) begin
          state_s = ST_IRQ;
        end else begin
          o_fetch  = 1'b1;
          opcode_s = i_opcode;
          step_s   = STEP_ZERO;
          if (len_of(i_opcode) == STEP_ZERO) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        o_exec = 1'b1;
        if (i_stall) begin
          state_s = ST_EXEC;
        end else if (last_step_s) begin
          o_done  = 1'b1;
          state_s = ST_FETCH;
          step_s  = STEP_ZERO;
        end else begin
          step_s = step_r + STEP_ONE;
        end
      end
      ST_IRQ: begin
        o_irq_ack = 1'b1;
        state_s   = ST_FETCH;
      end
      default: begin
        state_s = ST_IDLE;
        step_s  = STEP_ZERO;
      end
    endcase
  end

  // State, step and latched-opcode registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r  <= ST_IDLE;
      step_r   <= STEP_ZERO;
      opcode_r <= {OP_W{1'b0}};
    end else begin
      state_r  <= state_s;
      step_r   <= step_s;
      opcode_r <= opcode_s;
    end
  end

  assign o_state  = state_r;
  assign o_step   = step_r;
  assign o_opcode = opcode_r;

endmodule
